// File: rtl/fgen.sv
// fgen: host-programmed write sequencer.
// Plays a table of delayed slave-bus writes per trigger.
module fgen #(
  parameter int NENT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [31:0] lb_data,
  input  logic [15:0] lb_addr,
  input  logic        lb_write,
  output logic [31:0] lbo_data,
  output logic [15:0] lbo_addr,
  output logic        lbo_write,
  output logic        collision
);
  localparam int          IW   = $clog2(NENT);
  localparam logic [11:0] ELIM = 12'(2 * NENT);
  localparam logic [8:0]  LMAX = 9'(NENT);

  typedef enum logic {IDLE, PLAY} st_t;

  st_t         st_q, st_d;
  logic        en_q, en_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  plen_q, plen_d;
  logic [8:0]  idx_q, idx_d;
  logic        arm_q, arm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] lbo_data_q, lbo_data_d;
  logic [15:0] lbo_addr_q, lbo_addr_d;
  logic        lbo_write_q, lbo_write_d;
  logic        coll_q, coll_d;
  logic        fire;

  logic [31:0] ta [NENT];
  logic [31:0] tb [NENT];

  logic          ctrl_hit, ent_hit, ent_wr;
  logic [IW-1:0] ent_idx;
  logic [8:0]    len_in;
  logic [31:0]   cur_a, cur_b;
  logic [15:0]   cur_dly;

  assign ctrl_hit = lb_write && (lb_addr == 16'h0000);
  assign ent_hit  = lb_write && (lb_addr[15:12] == 4'h1)
                 && (lb_addr[11:0] < ELIM);
  assign ent_wr   = ent_hit && (st_q == IDLE);
  assign ent_idx  = lb_addr[IW:1];
  assign len_in   = lb_data[8:0];
  assign cur_a    = ta[idx_q[IW-1:0]];
  assign cur_b    = tb[idx_q[IW-1:0]];
  assign cur_dly  = cur_a[31:16];

  assign lbo_data  = lbo_data_q;
  assign lbo_addr  = lbo_addr_q;
  assign lbo_write = lbo_write_q;
  assign collision = coll_q;

  // Entry table: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (ent_wr) begin
      if (lb_addr[0]) tb[ent_idx] <= lb_data;
      else            ta[ent_idx] <= lb_data;
    end
  end

  // Next state: CTRL decode, start, per-entry arm/count/fire.
  always_comb begin
    st_d        = st_q;
    en_d        = en_q;
    len_d       = len_q;
    plen_d      = plen_q;
    idx_d       = idx_q;
    arm_d       = arm_q;
    cnt_d       = cnt_q;
    lbo_data_d  = lbo_data_q;
    lbo_addr_d  = lbo_addr_q;
    lbo_write_d = 1'b0;
    coll_d      = 1'b0;
    fire        = 1'b0;
    if (ctrl_hit) begin
      en_d  = lb_data[31];
      len_d = (len_in > LMAX) ? LMAX : len_in;
    end
    unique case (st_q)
      IDLE: begin
        if (trig && en_q && (len_q != 9'd0)) begin
          st_d   = PLAY;
          plen_d = len_q;
          idx_d  = 9'd0;
          arm_d  = 1'b1;
        end
      end
      PLAY: begin
        coll_d = trig | ent_hit;
        if (arm_q) begin
          if (idx_q == plen_q) begin
            st_d  = IDLE;
            arm_d = 1'b0;
          end else if (cur_dly == 16'd0) begin
            fire = 1'b1;
          end else begin
            cnt_d = cur_dly - 16'd1;
            arm_d = 1'b0;
          end
        end else if (cnt_q == 16'd0) begin
          fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
        if (fire) begin
          lbo_write_d = 1'b1;
          lbo_addr_d  = cur_a[15:0];
          lbo_data_d  = cur_b;
          idx_d       = idx_q + 9'd1;
          arm_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and output registers, cleared at once by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      en_q        <= 1'b0;
      len_q       <= 9'd0;
      plen_q      <= 9'd0;
      idx_q       <= 9'd0;
      arm_q       <= 1'b0;
      cnt_q       <= 16'd0;
      lbo_data_q  <= 32'd0;
      lbo_addr_q  <= 16'd0;
      lbo_write_q <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      en_q        <= en_d;
      len_q       <= len_d;
      plen_q      <= plen_d;
      idx_q       <= idx_d;
      arm_q       <= arm_d;
      cnt_q       <= cnt_d;
      lbo_data_q  <= lbo_data_d;
      lbo_addr_q  <= lbo_addr_d;
      lbo_write_q <= lbo_write_d;
      coll_q      <= coll_d;
    end
  end
endmodule

// File: tb/tb_fgen.sv
// tb_fgen: directed checks of the fgen sequencer.
// Cycle n ends at posedge n; outputs sampled at negedge.
module tb_fgen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] lb_data = '0;
  logic [15:0] lb_addr = '0;
  logic        lb_write = 1'b0;
  logic [31:0] lbo_data;
  logic [15:0] lbo_addr;
  logic        lbo_write;
  logic        collision;

  fgen #(.NENT(32)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig),
    .lb_data(lb_data), .lb_addr(lb_addr),
    .lb_write(lb_write), .lbo_data(lbo_data),
    .lbo_addr(lbo_addr), .lbo_write(lbo_write),
    .collision(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } hw_t;

  wr_t wlog[$];
  int  clog[$];

  always @(negedge clk) begin
    if (lbo_write) wlog.push_back('{cyc, lbo_addr, lbo_data});
    if (collision) clog.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic host_wr(logic [15:0] a, logic [31:0] d);
    lb_write = 1'b1;
    lb_addr  = a;
    lb_data  = d;
    @(negedge clk);
    lb_write = 1'b0;
  endtask

  task automatic pulse_trig(output int t0);
    trig = 1'b1;
    t0   = cyc;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clr();
    wlog.delete();
    clog.delete();
  endtask

  wr_t seq[3];
  hw_t prog[10];

  task automatic chk_play(string nm, int t0);
    check({nm, "_nwr"}, wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      check($sformatf("%s_cyc%0d", nm, i), wlog[i].c,
            t0 + seq[i].c);
      check($sformatf("%s_adr%0d", nm, i), wlog[i].a,
            seq[i].a);
      check($sformatf("%s_dat%0d", nm, i), wlog[i].d,
            seq[i].d);
    end
  endtask

  initial begin
    int t0;
    int t1;
    seq = '{'{2, 16'd5, 32'h11},
            '{5, 16'd6, 32'h22},
            '{6, 16'd7, 32'h33}};
    prog = '{'{16'h1000, 32'h0000_0005},
             '{16'h1001, 32'h0000_0011},
             '{16'h1002, 32'h0002_0006},
             '{16'h1003, 32'h0000_0022},
             '{16'h1004, 32'h0000_0007},
             '{16'h1005, 32'h0000_0033},
             '{16'h0000, 32'h8000_0003},
             '{16'h0001, 32'h0000_0000},
             '{16'h1040, 32'h0000_0009},
             '{16'h2000, 32'h0000_0000}};

    repeat (3) @(negedge clk);
    check("rst_wr", lbo_write, 0);
    check("rst_adr", lbo_addr, 0);
    check("rst_dat", lbo_data, 0);
    check("rst_col", collision, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) host_wr(prog[i].a, prog[i].d);
    clr();

    // Basic play, then back-to-back retrigger
    pulse_trig(t0);
    wait_to(t0 + 7);
    pulse_trig(t1);
    wait_to(t1 + 12);
    check("basic_ncol", clog.size(), 0);
    check("basic_nwr", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      int tb0;
      tb0 = (i < 3) ? t0 : t1;
      check($sformatf("basic_cyc%0d", i), wlog[i].c,
            tb0 + seq[i % 3].c);
      check($sformatf("basic_adr%0d", i), wlog[i].a,
            seq[i % 3].a);
      check($sformatf("basic_dat%0d", i), wlog[i].d,
            seq[i % 3].d);
    end
    check("hold_adr", lbo_addr, 7);
    check("hold_dat", lbo_data, 32'h33);
    check("hold_wr", lbo_write, 0);
    clr();

    // Trig in PLAY and CTRL write in PLAY
    pulse_trig(t0);
    host_wr(16'h0000, 32'h8000_0001);
    wait_to(t0 + 3);
    pulse_trig(t1);
    wait_to(t0 + 12);
    chk_play("trigplay", t0);
    check("trigplay_ncol", clog.size(), 1);
    if (clog.size() > 0)
      check("trigplay_ccyc", clog[0], t0 + 4);
    clr();
    pulse_trig(t0);
    wait_to(t0 + 12);
    check("len1_nwr", wlog.size(), 1);
    if (wlog.size() > 0) check("len1_adr", wlog[0].a, 5);
    host_wr(16'h0000, 32'h8000_0003);
    clr();

    // Entry write in PLAY, and trig+write together
    pulse_trig(t0);
    host_wr(16'h1003, 32'h0000_DEAD);
    wait_to(t0 + 3);
    trig     = 1'b1;
    lb_write = 1'b1;
    lb_addr  = 16'h1003;
    lb_data  = 32'h0000_BEEF;
    @(negedge clk);
    trig     = 1'b0;
    lb_write = 1'b0;
    wait_to(t0 + 12);
    chk_play("entplay", t0);
    check("entplay_ncol", clog.size(), 2);
    if (clog.size() > 1) begin
      check("entplay_c0", clog[0], t0 + 2);
      check("entplay_c1", clog[1], t0 + 4);
    end
    clr();
    pulse_trig(t0);
    wait_to(t0 + 12);
    chk_play("tbl_kept", t0);
    clr();

    // Disabled and zero-length CTRL ignore trig
    host_wr(16'h0000, 32'h0000_0003);
    pulse_trig(t0);
    wait_to(t0 + 10);
    host_wr(16'h0000, 32'h8000_0000);
    pulse_trig(t0);
    wait_to(t0 + 10);
    check("dis_nwr", wlog.size(), 0);
    check("dis_ncol", clog.size(), 0);
    host_wr(16'h0000, 32'h8000_0003);
    clr();

    // Reset mid-sequence
    pulse_trig(t0);
    wait_to(t0 + 3);
    rst_n = 1'b0;
    #1;
    check("arst_wr", lbo_write, 0);
    check("arst_adr", lbo_addr, 0);
    check("arst_dat", lbo_data, 0);
    check("arst_col", collision, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_to(t0 + 14);
    check("arst_nwr", wlog.size(), 1);
    if (wlog.size() > 0) check("arst_c0", wlog[0].c, t0 + 2);
    clr();
    pulse_trig(t0);
    wait_to(t0 + 10);
    check("arst_ctrl0", wlog.size(), 0);
    host_wr(16'h0000, 32'h8000_0003);
    clr();
    pulse_trig(t0);
    wait_to(t0 + 12);
    chk_play("arst_replay", t0);
    clr();

    // Entry write in the same cycle as the starting trig
    trig     = 1'b1;
    lb_write = 1'b1;
    lb_addr  = 16'h1001;
    lb_data  = 32'h0000_0099;
    t0       = cyc;
    @(negedge clk);
    trig     = 1'b0;
    lb_write = 1'b0;
    wait_to(t0 + 12);
    check("samecyc_ncol", clog.size(), 0);
    check("samecyc_nwr", wlog.size(), 3);
    if (wlog.size() > 0) check("samecyc_d0", wlog[0].d, 32'h99);
    host_wr(16'h1001, 32'h0000_0011);
    clr();

    // Maximum delay on entry 0
    host_wr(16'h1000, 32'hFFFF_0005);
    host_wr(16'h0000, 32'h8000_0001);
    clr();
    pulse_trig(t0);
    wait_to(t0 + 65545);
    check("maxd_nwr", wlog.size(), 1);
    if (wlog.size() > 0) check("maxd_cyc", wlog[0].c, t0 + 65537);
    check("maxd_ncol", clog.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fgen.md
FGEN -- requirements
Module: fgen

Interface
REQ-001 SHALL provide parameter NENT, default 32, meaning number of sequence entries (power of 2, 2..256).
REQ-002 SHALL provide port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port trig, input, 1, a sequence start request, sampled each cycle.
REQ-005 SHALL provide port lb_data, input, 32, host write data.
REQ-006 SHALL provide port lb_addr, input, 16, host write address.
REQ-007 SHALL provide port lb_write, input, 1, host write strobe (one cycle per write).
REQ-008 SHALL provide port lbo_data, output, 32, slave-bus write data.
REQ-009 SHALL provide port lbo_addr, output, 16, slave-bus write address.
REQ-010 SHALL provide port lbo_write, output, 1, slave-bus write strobe.
REQ-011 SHALL provide port collision, output, 1, registered conflict pulse.

Function
REQ-012 SHALL decode host address 0x0000 as CTRL: bit31 = enable, bits[8:0] = LEN (entries played; values above NENT are clamped to NENT).
REQ-013 SHALL decode host addresses 0x1000+2k, for k < NENT, as entry word A = {DELAY[31:16], TADDR[15:0]}.
REQ-014 SHALL decode host addresses 0x1001+2k as entry word B = TDATA[31:0].
REQ-015 SHALL ignore host writes to all other addresses, with no side effects.
REQ-016 SHALL use two states, IDLE and PLAY.
REQ-017 SHALL leave IDLE for PLAY when trig=1 in IDLE with enable=1 and LEN>0; cycle t0 is the cycle trig is sampled. LEN is latched at that point.
REQ-018 SHALL ignore trig in IDLE when enable=0 or LEN=0, with no collision.
REQ-019 SHALL play entries k = 0..LEN-1 in order. Entry k asserts lbo_write for exactly one cycle with lbo_addr = TADDR_k and lbo_data = TDATA_k.
REQ-020 SHALL time the write of entry 0 at cycle t0+2+DELAY_0.
REQ-021 SHALL time the write of entry k>0 at cycle W(k-1)+1+DELAY_k, where W(k-1) is the write cycle of entry k-1; DELAY=0 gives back-to-back writes.
REQ-022 SHALL return to IDLE in the cycle after the write of entry LEN-1; a trig in that following cycle starts a new sequence normally.
REQ-023 SHALL hold lbo_addr and lbo_data at their last written values while lbo_write=0.
REQ-024 SHALL pulse collision high for one cycle, the cycle after the event, when trig=1 in PLAY; that trig is ignored and the sequence continues unaffected.
REQ-025 SHALL pulse collision the same way when a host write to an entry address occurs in PLAY; that write is discarded.
REQ-026 SHALL apply host writes to CTRL in PLAY immediately, without collision, but SHALL NOT change the latched LEN of the running sequence.
REQ-027 SHALL produce a single collision pulse when a trig conflict and a write conflict occur in the same cycle.
REQ-028 SHALL store DELAY as unsigned 16-bit, so the maximum gap is 65536 cycles; the delay counter SHALL NOT wrap or truncate.
REQ-029 SHALL apply a host write to the entry table in IDLE in the same cycle a trig starts PLAY, with entry 0 reading the new value.

Reset
REQ-030 SHALL on rst_n=0 immediately force IDLE and set lbo_write=0, collision=0, lbo_addr=0, lbo_data=0 and CTRL=0, aborting any sequence in progress without completing further writes.
REQ-031 SHALL leave entry table contents unreset; they may be RAM and are undefined after power-up until written.

Verification
REQ-032 Bench SHALL program CTRL=0x80000003 and entries {0:(D0,A5,0x11),1:(D2,A6,0x22),2:(D0,A7,0x33)}, then trig at t0 -> writes addr5/0x11 at t0+2, addr6/0x22 at t0+5, addr7/0x33 at t0+6, then IDLE.
REQ-033 Bench SHALL apply trig during PLAY of the above -> collision=1 for one cycle and an identical write sequence.
REQ-034 Bench SHALL write entry 1 word B during PLAY -> collision pulse; the old value 0x22 is emitted and the table is unchanged afterward.
REQ-035 Bench SHALL set CTRL=0x00000003 (disabled) and apply trig -> no lbo_write and no collision.
REQ-036 Bench SHALL drop rst_n at t0+3 in the REQ-032 sequence -> all outputs 0 immediately, no further writes, and a later trig after re-enable replays from entry 0.
REQ-037 Bench SHALL set DELAY=0xFFFF on entry 0 -> first write at exactly t0+65537.
